pixel_out_formatter: RTL



---
 rtl/vdcm_out_pkg.sv | 40 ++++
 rtl/sync_fifo.sv | 79 +++++++
 rtl/pixel_out_formatter.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/vdcm_out_pkg.sv
// Shared constants, state and marker types for the pixel output formatter.
package vdcm_out_pkg;

    localparam int unsigned IN_SAMPLE_W   = 14;
    localparam int unsigned OUT_SAMPLE_W  = 12;
    localparam int unsigned PIX_PER_CYCLE = 4;
    localparam int unsigned NUM_COMP      = 3;
    localparam int unsigned NUM_SAMPLES   = PIX_PER_CYCLE * NUM_COMP;
    localparam int unsigned IN_GRP_W      = NUM_SAMPLES * IN_SAMPLE_W;
    localparam int unsigned OUT_GRP_W     = NUM_SAMPLES * OUT_SAMPLE_W;

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_e;

    typedef struct packed {
        logic sof;
        logic sol;
        logic eol;
        logic eof;
    } marker_t;

    localparam int unsigned MARKER_W = $bits(marker_t);

    // Saturate a signed sample into [0, 2^bpc - 1]; depths above 12 are treated as 12.
    function automatic logic [OUT_SAMPLE_W-1:0] clip_sample(
        input logic signed [IN_SAMPLE_W-1:0] s,
        input logic        [3:0]             bpc
    );
        logic        [3:0]             w_bpc;
        logic signed [IN_SAMPLE_W-1:0] w_max;
        w_bpc = (bpc > 4'd12) ? 4'd12 : bpc;
        w_max = $signed(IN_SAMPLE_W'((32'd1 << w_bpc) - 32'd1));
        if (s < 0) begin
            return '0;
        end else if (s > w_max) begin
            return w_max[OUT_SAMPLE_W-1:0];
        end
        return s[OUT_SAMPLE_W-1:0];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered first-word-fall-through head; DEPTH must be a power of two.
module sync_fifo #(
    parameter int unsigned WIDTH = 148,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [WIDTH-1:0] r_head;

    logic             w_do_wr;
    logic             w_do_rd;
    logic [AW:0]      w_remain;
    logic [AW:0]      w_count_n;
    logic [AW-1:0]    w_rd_ptr_n;
    logic [WIDTH-1:0] w_head_n;

    assign o_empty    = (r_count == '0);
    assign o_full     = (r_count == (AW+1)'(DEPTH));
    assign w_do_rd    = i_rd_en & ~o_empty;
    // A read in the same cycle frees a slot, so a write into a full FIFO still lands.
    assign w_do_wr    = i_wr_en & (~o_full | w_do_rd);
    assign w_remain   = r_count - (AW+1)'(w_do_rd);
    assign w_count_n  = w_remain + (AW+1)'(w_do_wr);
    assign w_rd_ptr_n = r_rd_ptr + AW'(w_do_rd);
    assign o_rd_data  = r_head;

    // The head always mirrors r_mem[r_rd_ptr]; bypass the array when the new word becomes head.
    always_comb begin
        w_head_n = r_head;
        if (w_count_n == '0) begin
            w_head_n = '0;
        end else if (w_remain == '0) begin
            w_head_n = i_wr_data;
        end else begin
            w_head_n = r_mem[w_rd_ptr_n];
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_wr && !i_flush) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(w_do_wr);
            r_rd_ptr <= w_rd_ptr_n;
            r_count  <= w_count_n;
            r_head   <= w_head_n;
        end
    end

endmodule

// File: rtl/pixel_out_formatter.sv
// Clips the 4-pixel reconstructed stream, tags slice/line framing and buffers it for the sink.
// Define PIX_OUT_DROP_CNT_EN to add the saturating o_drop_cnt overflow counter.
module pixel_out_formatter
    import vdcm_out_pkg::*;
#(
    parameter int unsigned MAX_SLICE_WIDTH  = 2560,
    parameter int unsigned MAX_SLICE_HEIGHT = 4096,
    parameter int unsigned FIFO_DEPTH       = 16
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                i_flush,
    input  logic [$clog2(MAX_SLICE_WIDTH)-1:0]  i_slice_width,
    input  logic [$clog2(MAX_SLICE_HEIGHT)-1:0] i_slice_height,
    input  logic [3:0]                          i_bits_per_component,
    input  logic                                i_in_sof,
    input  logic [IN_GRP_W-1:0]                 i_in_data_p,
    input  logic                                i_in_data_valid,
    input  logic                                i_out_ready,
    output logic                                o_out_valid,
    output logic [OUT_GRP_W-1:0]                o_out_data_p,
    output logic                                o_out_sof,
    output logic                                o_out_sol,
    output logic                                o_out_eol,
    output logic                                o_out_eof,
`ifdef PIX_OUT_DROP_CNT_EN
    output logic [15:0]                         o_drop_cnt,
`endif
    output logic                                o_ovf_err
);

    localparam int unsigned CW     = $clog2(MAX_SLICE_WIDTH);
    localparam int unsigned LW     = $clog2(MAX_SLICE_HEIGHT);
    localparam int unsigned ENTRY_W = OUT_GRP_W + MARKER_W;

    state_e               r_state;
    state_e               w_state_n;
    logic [CW-1:0]        r_col;
    logic [LW-1:0]        r_line;
    logic [CW-1:0]        w_col_n;
    logic [LW-1:0]        w_line_n;
    logic                 r_stg_vld;
    logic [OUT_GRP_W-1:0] r_stg_data;
    marker_t              r_stg_mk;
    logic                 r_ovf;

    logic                 w_accept;
    logic [CW-1:0]        w_col;
    logic [LW-1:0]        w_line;
    marker_t              w_mk;
    logic [OUT_GRP_W-1:0] w_clip;
    logic [ENTRY_W-1:0]   w_fifo_rdata;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic                 w_drop;
    marker_t              w_head_mk;

    // in_sof restarts the slice, so a coincident valid group is position (0,0).
    assign w_accept = i_in_data_valid & ((r_state == ACTIVE) | i_in_sof);
    assign w_col    = i_in_sof ? '0 : r_col;
    assign w_line   = i_in_sof ? '0 : r_line;

    always_comb begin
        w_mk.sol = (w_col == '0);
        w_mk.eol = (({1'b0, w_col} + (CW+1)'(PIX_PER_CYCLE)) == {1'b0, i_slice_width});
        w_mk.sof = w_mk.sol & (w_line == '0);
        w_mk.eof = w_mk.eol & (w_line == (i_slice_height - LW'(1)));
    end

    always_comb begin
        w_clip = '0;
        for (int k = 0; k < NUM_SAMPLES; k++) begin
            w_clip[k*OUT_SAMPLE_W +: OUT_SAMPLE_W] =
                clip_sample($signed(i_in_data_p[k*IN_SAMPLE_W +: IN_SAMPLE_W]),
                            i_bits_per_component);
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_col_n   = r_col;
        w_line_n  = r_line;
        if (w_accept) begin
            if (w_mk.eol) begin
                w_col_n  = '0;
                w_line_n = w_line + LW'(1);
            end else begin
                w_col_n  = w_col + CW'(PIX_PER_CYCLE);
                w_line_n = w_line;
            end
        end else if (i_in_sof) begin
            w_col_n  = '0;
            w_line_n = '0;
        end
        if (w_accept && w_mk.eof) begin
            w_state_n = DONE;
        end else if (i_in_sof) begin
            w_state_n = ACTIVE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_col      <= '0;
            r_line     <= '0;
            r_stg_vld  <= 1'b0;
            r_stg_data <= '0;
            r_stg_mk   <= '0;
        end else if (i_flush) begin
            r_state    <= IDLE;
            r_col      <= '0;
            r_line     <= '0;
            r_stg_vld  <= 1'b0;
            r_stg_data <= '0;
            r_stg_mk   <= '0;
        end else begin
            r_state   <= w_state_n;
            r_col     <= w_col_n;
            r_line    <= w_line_n;
            r_stg_vld <= w_accept;
            if (w_accept) begin
                r_stg_data <= w_clip;
                r_stg_mk   <= w_mk;
            end
        end
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_flush   (i_flush),
        .i_wr_en   (r_stg_vld),
        .i_wr_data ({r_stg_mk, r_stg_data}),
        .i_rd_en   (i_out_ready),
        .o_rd_data (w_fifo_rdata),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty)
    );

    // A staged group is lost only when the FIFO is full and no slot frees this cycle.
    assign w_drop = r_stg_vld & w_fifo_full & ~(i_out_ready & ~w_fifo_empty);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (i_flush) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end
    end

`ifdef PIX_OUT_DROP_CNT_EN
    logic [15:0] r_drop_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
        end else if (i_flush) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign o_drop_cnt = r_drop_cnt;
`endif

    assign w_head_mk    = marker_t'(w_fifo_rdata[OUT_GRP_W +: MARKER_W]);
    assign o_out_valid  = ~w_fifo_empty;
    assign o_out_data_p = w_fifo_rdata[OUT_GRP_W-1:0];
    assign o_out_sof    = w_head_mk.sof;
    assign o_out_sol    = w_head_mk.sol;
    assign o_out_eol    = w_head_mk.eol;
    assign o_out_eof    = w_head_mk.eof;
    assign o_ovf_err    = r_ovf;

endmodule
